// File: rtl/frac_multiplier.sv
// -----------------------------------------------------------------------------
// frac_multiplier
//
// Sequential radix-2 shift-add fractional multiplier, p = q * b. It is the
// inverse of the fractional divider: feeding it the divider's quotient and
// divisor reconstructs the dividend. It is used for remainder/consistency
// checks and for scaling by fractional gains.
//
// Number formats (plain descending vectors, bit weights noted):
//   b : ni bits,   b[ni-1] weighs 2^-1 ... b[0] weighs 2^-ni   (0.bbbb)
//   q : no+1 bits, q[no] weighs 2^0, q[no-1] weighs 2^-1 ... q[0] weighs 2^-no
//   p : ni+1 bits, p[ni] weighs 2^0,  p[ni-1] weighs 2^-1 ... p[0] weighs 2^-ni
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    sample operands and begin; ignored while busy
//   b        multiplicand (pure fraction)
//   q        multiplier (1 integer bit + no fraction bits)
//   busy     high while an operation is in progress
//   done     one-cycle pulse; p and inexact are valid from this cycle
//   p        product, stable until the next done
//   inexact  some discarded product bit below 2^-ni was nonzero
//
// Latency: start sampled at edge E, done high after edge E+no+1.
//
// Optional feature: define FRAC_MULTIPLIER_ROUND_EN for round-to-nearest
// (ties up, saturating). Without it the product is truncated (floor).
// -----------------------------------------------------------------------------
module frac_multiplier #(
  parameter int ni = 32,
  parameter int no = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [ni-1:0] b,
  input  logic [no:0]   q,
  output logic          busy,
  output logic          done,
  output logic [ni:0]   p,
  output logic          inexact
);

  localparam int cw = $clog2(no + 1);
  localparam logic [cw-1:0] last = cw'(no - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ni-1:0]   breg;
  logic [no:0]     mq;
  logic [ni+1:0]   acc;
  logic [ni+1:0]   sum;
  logic [ni:0]     pfinal;
  logic            sticky;
  logic            inexact_nxt;
  logic [cw-1:0]   count;

`ifdef FRAC_MULTIPLIER_ROUND_EN
  logic            guard;
  logic [ni+1:0]   rnd;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: no RUN cycles, then one FIN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Conditional add of b. The same adder serves RUN (followed by a shift)
  // and FIN, where the multiplier register has shifted q[no] (the integer
  // bit) down to its LSB. Sums stay below 2, so the carry bit never sets
  // in FIN and is only a headroom bit during RUN.
  always_comb begin
    sum = acc + (mq[0] ? {2'b00, breg} : '0);
`ifdef FRAC_MULTIPLIER_ROUND_EN
    // Round half up on the guard bit; saturate if rounding reaches 2.0.
    rnd         = sum + {{(ni + 1){1'b0}}, guard};
    pfinal      = rnd[ni+1] ? '1 : rnd[ni:0];
    inexact_nxt = guard | sticky;
`else
    pfinal      = sum[ni:0];
    inexact_nxt = sticky;
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breg    <= '0;
      mq      <= '0;
      acc     <= '0;
      sticky  <= 1'b0;
      count   <= '0;
      p       <= '0;
      inexact <= 1'b0;
      done    <= 1'b0;
`ifdef FRAC_MULTIPLIER_ROUND_EN
      guard   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            breg   <= b;
            mq     <= q;
            acc    <= '0;
            sticky <= 1'b0;
            count  <= '0;
`ifdef FRAC_MULTIPLIER_ROUND_EN
            guard  <= 1'b0;
`endif
          end
        end
        RUN: begin
          acc   <= {1'b0, sum[ni+1:1]};
          mq    <= mq >> 1;
          count <= count + 1'b1;
`ifdef FRAC_MULTIPLIER_ROUND_EN
          // The most recent shifted-out bit is the guard; older ones
          // collapse into sticky.
          guard  <= sum[0];
          sticky <= sticky | guard;
`else
          sticky <= sticky | sum[0];
`endif
        end
        FIN: begin
          p       <= pfinal;
          inexact <= inexact_nxt;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_multiplier.sv
// -----------------------------------------------------------------------------
// tb_frac_multiplier
//
// Directed self-checking bench for frac_multiplier (ni=32, no=40). Expected
// values are hand-computed; the rounding build is selected with
// FRAC_MULTIPLIER_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_frac_multiplier;

  localparam int NI = 32;
  localparam int NO = 40;

  localparam logic [NO:0] Q_ONE  = 41'h100_0000_0000;
  localparam logic [NO:0] Q_HALF = 41'h080_0000_0000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NI-1:0] b;
  logic [NO:0]   q;
  logic          busy;
  logic          done;
  logic [NI:0]   p;
  logic          inexact;

  int checks = 0;
  int fails  = 0;

  frac_multiplier #(.ni(NI), .no(NO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .b       (b),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .p       (p),
    .inexact (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with a single-cycle start pulse. Returns at the
  // negedge just after the sampling edge.
  task automatic applyStimulus(input logic [NI-1:0] bv, input logic [NO:0] qv);
    @(negedge clk);
    b     = bv;
    q     = qv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count clock edges after the start edge until done, bounded.
  task automatic waitDone(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Full operation with latency, result and pulse-width checks.
  task automatic runCase(input string tag, input logic [NI-1:0] bv,
                         input logic [NO:0] qv, input logic [NI:0] pexp,
                         input logic iexp);
    int cyc;
    applyStimulus(bv, qv);
    checkOutput({tag, ".busy_run"}, 64'(busy), 64'd1);
    waitDone(cyc);
    checkOutput({tag, ".latency"}, 64'(cyc), 64'(NO + 1));
    checkOutput({tag, ".p"}, 64'(p), 64'(pexp));
    checkOutput({tag, ".inexact"}, 64'(inexact), 64'(iexp));
    checkOutput({tag, ".busy_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  int          doneCount;
  int          firstDone;
  int          secondDone;
  logic [NI:0] pFirst;
  logic [NI:0] pSecond;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    b     = '0;
    q     = '0;

    // Reset state.
    #12;
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.p", 64'(p), 64'd0);
    checkOutput("reset.inexact", 64'(inexact), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0.5 * 1.0 = 0.5
    runCase("basic", 32'h8000_0000, Q_ONE, 33'h0_8000_0000, 1'b0);
    // 0.5 * 0.5 = 0.25
    runCase("half_half", 32'h8000_0000, Q_HALF, 33'h0_4000_0000, 1'b0);
    // q = 0 gives zero regardless of b
    runCase("q_zero", 32'hFFFF_FFFF, '0, 33'h0, 1'b0);
    // (1-2^-32) * 1.0 is exact
    runCase("b_max_q_one", 32'hFFFF_FFFF, Q_ONE, 33'h0_FFFF_FFFF, 1'b0);
    // Round-trip: 0.375 / 0.75 = 0.5 exactly, so 0.5 * 0.75 returns a
    runCase("round_trip", 32'hC000_0000, Q_HALF, 33'h0_6000_0000, 1'b0);
`ifdef FRAC_MULTIPLIER_ROUND_EN
    // 2^-32 * 0.5 = 2^-33: exactly half an ulp, ties up to one ulp
    runCase("half_ulp", 32'h0000_0001, Q_HALF, 33'h0_0000_0001, 1'b1);
    // (1-2^-32)*(2-2^-40) = 2 - 2^-31 - 2^-40 + 2^-72 rounds to 1.FFFFFFFE
    runCase("max_ops", 32'hFFFF_FFFF, '1, 33'h1_FFFF_FFFE, 1'b1);
`else
    runCase("half_ulp", 32'h0000_0001, Q_HALF, 33'h0_0000_0000, 1'b1);
    runCase("max_ops", 32'hFFFF_FFFF, '1, 33'h1_FFFF_FFFD, 1'b1);
`endif

    // Handshake: starts while busy are ignored; a start during the done
    // cycle is accepted on the next edge and finishes NO+2 edges later.
    applyStimulus(32'h8000_0000, Q_ONE);
    doneCount  = 0;
    firstDone  = -1;
    secondDone = -1;
    pFirst     = '0;
    pSecond    = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = n;
          pFirst    = p;
          b         = 32'hC000_0000;
          q         = Q_HALF;
          start     = 1'b1;
        end else begin
          secondDone = n;
          pSecond    = p;
        end
      end
      if (n == 5 || n == 20) begin
        b     = '1;
        q     = '1;
        start = 1'b1;
      end
    end
    checkOutput("hs.done_count", 64'(doneCount), 64'd2);
    checkOutput("hs.first_done", 64'(firstDone), 64'(NO + 1));
    checkOutput("hs.second_done", 64'(secondDone), 64'(2 * NO + 3));
    checkOutput("hs.first_p", 64'(pFirst), 64'h0_8000_0000);
    checkOutput("hs.second_p", 64'(pSecond), 64'h0_6000_0000);

    // Reset in mid-operation aborts it with no done afterwards.
    applyStimulus(32'hFFFF_FFFF, '1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.done", 64'(done), 64'd0);
    checkOutput("abort.p", 64'(p), 64'd0);
    checkOutput("abort.inexact", 64'(inexact), 64'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort.no_done", 64'(doneCount), 64'd0);
    runCase("after_reset", 32'h8000_0000, Q_HALF, 33'h0_4000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
